// File: rtl/norm_pkg.sv
// norm_pkg: shared widths, stage record and bit-reverse helper for norm_shift
package norm_pkg;
    localparam int WIDTH = 32;
    localparam int SW = 5;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             dir;
        logic [SW-1:0]    cnt;
        logic             zero;
        logic             valid;
    } stage_t;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
        return r;
    endfunction
endpackage

// File: rtl/norm_shift_lzc32.sv
// lzc32: combinational leading-zero counter
//   word  in  WIDTH  word to scan from the MSB down
//   count out SW     number of leading zeros (0 when word is all-zero)
//   zero  out 1      word is all-zero
module lzc32
    import norm_pkg::*;
(
    input  logic [WIDTH-1:0] word,
    output logic [SW-1:0]    count,
    output logic             zero
);
    // Scanning upward lets the highest set bit be the last writer.
    always_comb begin
        count = '0;
        zero  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (word[i]) begin
                count = SW'(WIDTH - 1 - i);
                zero  = 1'b0;
            end
        end
    end
endmodule

// File: rtl/norm_shift.sv
// norm_shift: three-stage pipelined normalizer (leading/trailing one to word boundary)
//   clk      in  1      rising-edge clock
//   reset    in  1      asynchronous active-low reset
//   I        in  WIDTH  word to normalize
//   R        in  1      0 = left-normalize, 1 = right-normalize
//   I_valid  in  1      I/R valid
//   I_ready  out 1      block accepts this cycle
//   O        out WIDTH  normalized word
//   S        out SW     shift amount applied
//   Z        out 1      input word was all-zero
//   O_valid  out 1      O/S/Z valid
//   O_ready  in  1      downstream accepts
module norm_shift
    import norm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] I,
    input  logic             R,
    input  logic             I_valid,
    output logic             I_ready,
    output logic [WIDTH-1:0] O,
    output logic [SW-1:0]    S,
    output logic             Z,
    output logic             O_valid,
    input  logic             O_ready
);
    logic [WIDTH-1:0] s1_data;
    logic             s1_dir;
    logic             s1_valid;
    stage_t           s2;
    logic             adv;
    logic [WIDTH-1:0] enc_in;
    logic [SW-1:0]    enc_cnt;
    logic             enc_zero;
    logic [WIDTH-1:0] sh;

    // One global enable: the whole pipe moves or the whole pipe holds.
    assign adv     = ~O_valid | O_ready;
    assign I_ready = adv;

    // Trailing-zero count is the leading-zero count of the mirrored word.
    assign enc_in = s1_dir ? bit_rev(s1_data) : s1_data;

    lzc32 u_lzc (
        .word  (enc_in),
        .count (enc_cnt),
        .zero  (enc_zero)
    );

    // Logarithmic shifter: one level per bit of the count.
    always_comb begin
        sh = s2.data;
        for (int k = 0; k < SW; k++) begin
            if (s2.cnt[k]) sh = s2.dir ? sh >> (1 << k) : sh << (1 << k);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_data  <= '0;
            s1_dir   <= 1'b0;
            s1_valid <= 1'b0;
            s2       <= '0;
            O        <= '0;
            S        <= '0;
            Z        <= 1'b0;
            O_valid  <= 1'b0;
        end else if (adv) begin
            s1_data  <= I;
            s1_dir   <= R;
            s1_valid <= I_valid;
            s2       <= '{data: s1_data, dir: s1_dir, cnt: enc_cnt, zero: enc_zero, valid: s1_valid};
            O        <= sh;
            S        <= s2.cnt;
            Z        <= s2.zero;
            O_valid  <= s2.valid;
        end
    end
endmodule

// File: tb/tb_norm_shift.sv
// tb_norm_shift: directed and round-trip checks for norm_shift
module tb_norm_shift;
    typedef struct packed {
        logic [31:0] i;
        logic        r;
        logic [31:0] o;
        logic [4:0]  s;
        logic        z;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] I;
    logic        R;
    logic        I_valid;
    logic        I_ready;
    logic [31:0] O;
    logic [4:0]  S;
    logic        Z;
    logic        O_valid;
    logic        O_ready;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t dir_v [8];
    vec_t str_v [8];

    norm_shift dut (
        .clk     (clk),
        .reset   (reset),
        .I       (I),
        .R       (R),
        .I_valid (I_valid),
        .I_ready (I_ready),
        .O       (O),
        .S       (S),
        .Z       (Z),
        .O_valid (O_valid),
        .O_ready (O_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b0; O_ready = 1'b1; I_valid = 1'b0; I = '0; R = 1'b0;
        #2;
        n_vec++;
        if ({O_valid, O, S, Z, I_ready} !== {1'b0, 32'h0, 5'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_during got V=%b O=%h S=%0d Z=%b RDY=%b want V=0 O=0 S=0 Z=0 RDY=1", O_valid, O, S, Z, I_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({O_valid, O, S, Z, I_ready} !== {1'b0, 32'h0, 5'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_after got V=%b O=%h S=%0d Z=%b RDY=%b want V=0 O=0 S=0 Z=0 RDY=1", O_valid, O, S, Z, I_ready);
        end
    endtask

    task automatic test_directed();
        for (int k = 0; k < 8; k++) begin
            I = dir_v[k].i; R = dir_v[k].r; I_valid = 1'b1;
            @(posedge clk); #1 I_valid = 1'b0;
            @(posedge clk); #1;
            n_vec++;
            if (O_valid !== 1'b0) begin
                n_err++;
                $display("FAIL directed_latency k=%0d got V=%b want V=0", k, O_valid);
            end
            @(posedge clk); #1;
            n_vec++;
            if ({O_valid, O, S, Z} !== {1'b1, dir_v[k].o, dir_v[k].s, dir_v[k].z}) begin
                n_err++;
                $display("FAIL directed k=%0d got V=%b O=%h S=%0d Z=%b want V=1 O=%h S=%0d Z=%b",
                         k, O_valid, O, S, Z, dir_v[k].o, dir_v[k].s, dir_v[k].z);
            end
        end
    endtask

    task automatic test_back_to_back();
        I = str_v[0].i; R = str_v[0].r; I_valid = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            if (c < 7) begin
                I = str_v[c+1].i; R = str_v[c+1].r;
            end else I_valid = 1'b0;
            n_vec++;
            if (c >= 2 && c < 10) begin
                if ({O_valid, I_ready, O, S, Z} !== {1'b1, 1'b1, str_v[c-2].o, str_v[c-2].s, str_v[c-2].z}) begin
                    n_err++;
                    $display("FAIL b2b c=%0d got V=%b RDY=%b O=%h S=%0d Z=%b want V=1 RDY=1 O=%h S=%0d Z=%b",
                             c, O_valid, I_ready, O, S, Z, str_v[c-2].o, str_v[c-2].s, str_v[c-2].z);
                end
            end else if (O_valid !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_bubble c=%0d got V=%b want V=0", c, O_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic acc = 1'b0;
                    I = str_v[i].i; R = str_v[i].r; I_valid = 1'b1;
                    for (int t = 0; t < 30 && !acc; t++) begin
                        @(negedge clk) acc = I_ready;
                        @(posedge clk); #1;
                    end
                end
                I_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 O_ready = 1'b0;
                for (int t = 0; t < 5; t++) begin
                    @(negedge clk);
                    n_vec++;
                    if ({O_valid, I_ready, O, S, Z} !== {1'b1, 1'b0, str_v[1].o, str_v[1].s, str_v[1].z}) begin
                        n_err++;
                        $display("FAIL stall t=%0d got V=%b RDY=%b O=%h S=%0d Z=%b want V=1 RDY=0 O=%h S=%0d Z=%b",
                                 t, O_valid, I_ready, O, S, Z, str_v[1].o, str_v[1].s, str_v[1].z);
                    end
                    @(posedge clk); #1;
                end
                O_ready = 1'b1;
            end
            begin
                for (int t = 0; t < 60 && idx < 8; t++) begin
                    @(negedge clk);
                    if (O_valid && O_ready) begin
                        n_vec++;
                        if ({O, S, Z} !== {str_v[idx].o, str_v[idx].s, str_v[idx].z}) begin
                            n_err++;
                            $display("FAIL bp_order idx=%0d got O=%h S=%0d Z=%b want O=%h S=%0d Z=%b",
                                     idx, O, S, Z, str_v[idx].o, str_v[idx].s, str_v[idx].z);
                        end
                        idx++;
                    end
                end
                n_vec++;
                if (idx != 8) begin
                    n_err++;
                    $display("FAIL bp_count got %0d words want 8", idx);
                end
                repeat (4) @(negedge clk);
                n_vec++;
                if (O_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_extra got V=%b want V=0", O_valid);
                end
            end
        join
        @(posedge clk); #1;
    endtask

    task automatic test_reset_flush();
        I = str_v[0].i; R = str_v[0].r; I_valid = 1'b1;
        @(posedge clk); #1 I = str_v[1].i; R = str_v[1].r;
        @(posedge clk); #1 I = str_v[2].i; R = str_v[2].r;
        @(posedge clk); #1 I_valid = 1'b0;
        n_vec++;
        if ({O_valid, O} !== {1'b1, str_v[0].o}) begin
            n_err++;
            $display("FAIL flush_pre got V=%b O=%h want V=1 O=%h", O_valid, O, str_v[0].o);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({O_valid, O, S, Z, I_ready} !== {1'b0, 32'h0, 5'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL flush_async got V=%b O=%h S=%0d Z=%b RDY=%b want V=0 O=0 S=0 Z=0 RDY=1", O_valid, O, S, Z, I_ready);
        end
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #1;
            n_vec++;
            if (O_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_stale t=%0d got V=%b want V=0", t, O_valid);
            end
        end
        I = str_v[5].i; R = str_v[5].r; I_valid = 1'b1;
        @(posedge clk); #1 I_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (O_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_post_latency got V=%b want V=0", O_valid);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({O_valid, O, S, Z} !== {1'b1, str_v[5].o, str_v[5].s, str_v[5].z}) begin
            n_err++;
            $display("FAIL flush_post got V=%b O=%h S=%0d Z=%b want V=1 O=%h S=%0d Z=%b",
                     O_valid, O, S, Z, str_v[5].o, str_v[5].s, str_v[5].z);
        end
    endtask

    task automatic test_round_trip();
        logic [31:0] ri [1000];
        logic        rr [1000];
        logic [31:0] rec;
        logic        norm;
        for (int k = 0; k < 1000; k++) begin
            ri[k] = ($urandom >> $urandom_range(0, 31)) << $urandom_range(0, 31);
            rr[k] = 1'($urandom_range(0, 1));
        end
        I = ri[0]; R = rr[0]; I_valid = 1'b1;
        for (int c = 0; c < 1002; c++) begin
            @(posedge clk); #1;
            if (c < 999) begin
                I = ri[c+1]; R = rr[c+1];
            end else I_valid = 1'b0;
            if (c >= 2) begin
                rec  = rr[c-2] ? (O << S) : (O >> S);
                norm = (ri[c-2] == 32'h0) ? (O == 32'h0 && S == 5'd0 && Z)
                                          : (!Z && (rr[c-2] ? O[0] : O[31]));
                n_vec++;
                if (!(O_valid === 1'b1 && rec === ri[c-2] && norm === 1'b1)) begin
                    n_err++;
                    $display("FAIL round_trip k=%0d got V=%b O=%h S=%0d Z=%b rebuilt=%h want rebuilt=%h normalized",
                             c-2, O_valid, O, S, Z, rec, ri[c-2]);
                end
            end
        end
    endtask

    initial begin
        dir_v[0] = '{32'h000010EE, 1'b0, 32'h87700000, 5'd19, 1'b0};
        dir_v[1] = '{32'h000010EE, 1'b1, 32'h00000877, 5'd1,  1'b0};
        dir_v[2] = '{32'h80000000, 1'b0, 32'h80000000, 5'd0,  1'b0};
        dir_v[3] = '{32'h80000000, 1'b1, 32'h00000001, 5'd31, 1'b0};
        dir_v[4] = '{32'h00000001, 1'b0, 32'h80000000, 5'd31, 1'b0};
        dir_v[5] = '{32'h00000001, 1'b1, 32'h00000001, 5'd0,  1'b0};
        dir_v[6] = '{32'h00000000, 1'b0, 32'h00000000, 5'd0,  1'b1};
        dir_v[7] = '{32'h00000000, 1'b1, 32'h00000000, 5'd0,  1'b1};
        str_v[0] = '{32'h00000003, 1'b0, 32'hC0000000, 5'd30, 1'b0};
        str_v[1] = '{32'h00F00000, 1'b1, 32'h0000000F, 5'd20, 1'b0};
        str_v[2] = '{32'h7FFFFFFF, 1'b0, 32'hFFFFFFFE, 5'd1,  1'b0};
        str_v[3] = '{32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 5'd0,  1'b0};
        str_v[4] = '{32'h00012340, 1'b0, 32'h91A00000, 5'd15, 1'b0};
        str_v[5] = '{32'h00012340, 1'b1, 32'h0000048D, 5'd6,  1'b0};
        str_v[6] = '{32'h00000000, 1'b1, 32'h00000000, 5'd0,  1'b1};
        str_v[7] = '{32'h40000000, 1'b1, 32'h00000001, 5'd30, 1'b0};
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
